multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style main control FSM for the multi-cycle MIPS core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 6-bit ALUOp consumed by the ALU control decoder, plus the datapath mux selects and memory/register strobes.
- Memory accesses use a ready handshake, so the controller stalls on slow memory.

Parameters:
- ST_W, 4, width of the state register.
- OP_ADDI, 6'b001000, ALUOp driven for PC+4 and branch-target computation.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26]; stable from DECODE until return to FETCH.
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- pc_write  output  1  PC load enable.
- ir_write  output  1  IR load enable.
- iord  output  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- mem_size  output  2  00 word, 01 half, 10 byte.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write-data select: 0 = ALUOut, 1 = MDR.
- alu_src_a  output  1  0 = PC, 1 = reg A.
- alu_src_b  output  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- alu_op  output  6  ALUOp to the ALU control decoder.
- pc_source  output  2  00 = ALU result, 01 = ALUOut (branch target).
- illegal  output  1  one-cycle flag: unsupported opcode or funct.
- state  output  4  current state, for debug.

Behaviour:
- Reset: rst is asynchronous and active-high. It forces state = FETCH (0). While rst is high, every strobe (pc_write, ir_write, mem_read, mem_write, reg_write, illegal) is 0.
- Mid-instruction reset: rst asserted mid-instruction aborts the instruction; no further writes occur.
- Outputs: decoded from the state register only, with these exceptions: ir_write/pc_write in FETCH are gated by mem_ready, and pc_write in BRANCH is gated by zero.
- Default output values: all unlisted outputs are 0, and alu_op defaults to OP_ADDI.

States:
- FETCH (0):
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Next: DECODE if mem_ready, else stay.
- DECODE (1):
  - Outputs: alu_src_a=0, alu_src_b=11 (branch target into ALUOut).
  - Next by opcode: R-type 000000 with supported funct (add, sub, and, or, slt, sll, srl, sra, xor, nor) -> EXEC. Loads/stores lw 100010, lh 100001, lb 100000, sw 101010, sh 101001, sb 101000 -> MEMADR. addi/andi/ori/slti/xori (001000/001100/001101/001010/001110) -> IEXEC. beq 000100 / bne 000101 -> BRANCH.
  - Any other opcode or funct: illegal=1 for this cycle, next FETCH.
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=opcode. Next MEMRD if opcode[3]=0 (load), else MEMWR.
- MEMRD (3): mem_read=1, iord=1, mem_size from opcode. Next MEMWB when mem_ready, else stay.
- MEMWB (4): reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEMWR (5): mem_write=1, iord=1, mem_size from opcode. Next FETCH when mem_ready, else stay.
- EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=000000. Next RWB.
- RWB (7): reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- IEXEC (8): alu_src_a=1, alu_src_b=10, alu_op=opcode. Next IWB.
- IWB (9): reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- BRANCH (10):
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=opcode, pc_source=01.
  - pc_write = (opcode==beq & zero) | (opcode==bne & ~zero).
  - Next FETCH.
- Encodings 11-15: unreachable; if entered, next FETCH with all strobes 0.
- mem_size decode: lw/sw 00, lh/sh 01, lb/sb 10. Outside MEMRD/MEMWR, mem_size=00.
- Cycle counts with mem_ready tied high: R-type 4, I-ALU 4, branch 3, load 5, store 4.
- Memory stalls: each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. Request strobes stay asserted and stable for the whole stall.

Test Plan:
- Reset mid-MEMRD (async rst pulse between clock edges) -> state=0 immediately, mem_read=0 during reset; after release, FETCH with mem_read=1.
- Opcode 000000, funct 100000, mem_ready=1 -> state sequence 0,1,6,7,0; alu_op=000000 in EXEC; reg_write=1, reg_dst=1 only in RWB.
- lh (100001), mem_ready low 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; mem_size=01 and iord=1 throughout MEMRD; reg_write=1, mem_to_reg=1 in MEMWB.
- beq with zero=1 -> pc_write=1, pc_source=01 in BRANCH. Repeat with zero=0 -> pc_write=0. bne with zero=0 -> pc_write=1.
- xori (001110) -> states 0,1,8,9,0; alu_op=001110 and alu_src_b=10 in IEXEC; reg_dst=0 in IWB.
- Opcode 111111, and separately R-type funct 001000 -> illegal=1 for exactly one cycle in DECODE, next state 0, no reg_write or mem_write at any point.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS core.
// Walks fetch/decode/execute/memory/writeback and stalls on mem_ready.
module multicycle_control #(
  parameter int          ST_W    = 4,
  parameter logic [5:0]  OP_ADDI = 6'b001000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ir_write,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      mem_size,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [5:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  localparam logic [ST_W-1:0] S_FETCH  = ST_W'(0);
  localparam logic [ST_W-1:0] S_DECODE = ST_W'(1);
  localparam logic [ST_W-1:0] S_MEMADR = ST_W'(2);
  localparam logic [ST_W-1:0] S_MEMRD  = ST_W'(3);
  localparam logic [ST_W-1:0] S_MEMWB  = ST_W'(4);
  localparam logic [ST_W-1:0] S_MEMWR  = ST_W'(5);
  localparam logic [ST_W-1:0] S_EXEC   = ST_W'(6);
  localparam logic [ST_W-1:0] S_RWB    = ST_W'(7);
  localparam logic [ST_W-1:0] S_IEXEC  = ST_W'(8);
  localparam logic [ST_W-1:0] S_IWB    = ST_W'(9);
  localparam logic [ST_W-1:0] S_BRANCH = ST_W'(10);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;
  logic            r_ok;
  logic            is_r;
  logic            is_mem;
  logic            is_imm;
  logic            is_br;
  logic [1:0]      size;

  assign state = state_q;

  always_comb begin
    r_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b101010, 6'b000000,
      6'b000010, 6'b000011, 6'b100110,
      6'b100111: r_ok = 1'b1;
      default:   r_ok = 1'b0;
    endcase
  end

  always_comb begin
    is_r   = 1'b0;
    is_mem = 1'b0;
    is_imm = 1'b0;
    is_br  = 1'b0;
    case (opcode)
      6'b000000: is_r = r_ok;
      6'b100010, 6'b100001, 6'b100000,
      6'b101010, 6'b101001, 6'b101000:
        is_mem = 1'b1;
      6'b001000, 6'b001100, 6'b001101,
      6'b001010, 6'b001110:
        is_imm = 1'b1;
      OP_BEQ, OP_BNE: is_br = 1'b1;
      default: ;
    endcase
  end

  // opcode[1:0] is 10 word, 01 half, 00 byte for every load/store
  always_comb begin
    case (opcode[1:0])
      2'b01:   size = 2'b01;
      2'b00:   size = 2'b10;
      default: size = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:
        state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_r:    state_d = S_EXEC;
          is_mem:  state_d = S_MEMADR;
          is_imm:  state_d = S_IEXEC;
          is_br:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = opcode[3] ? S_MEMWR : S_MEMRD;
      S_MEMRD:
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:
        state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:  state_d = S_RWB;
      S_IEXEC: state_d = S_IWB;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_size   = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = OP_ADDI;
    pc_source  = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = ~(is_r | is_mem | is_imm | is_br);
      end
      S_MEMADR, S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = opcode;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        mem_size = size;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        mem_size  = size;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 6'b000000;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_IWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = opcode;
        pc_source = 2'b01;
        pc_write  = (opcode == OP_BEQ & zero) |
                    (opcode == OP_BNE & ~zero);
      end
      default: ;
    endcase
    // state already reads FETCH under reset; keep its strobes quiet
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule
